// File: rtl/prefix_add_seq.sv
// Multi-byte add/subtract sequencer: one 8-bit prefix-adder pass per cycle, LSB first,
// with the carry chained between byte passes and valid/ready handshakes on both sides.
module prefix_add_seq #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout,
   output logic                  ovf
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned KW = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;

   logic [7:0]      byte_a, byte_b, byte_s;
   logic            byte_c;
   logic [7:0]      g, p, gp, pp, gn, pn;

   // Kogge-Stone prefix tree over the current byte; carry_q acts as the carry into bit 0.
   always_comb begin
      byte_a = 8'(a_q >> {k_q, 3'b000});
      byte_b = 8'(b_q >> {k_q, 3'b000});
      g      = byte_a & byte_b;
      p      = byte_a ^ byte_b;
      gp     = g;
      pp     = p;
      gn     = '0;
      pn     = '0;
      for (int unsigned d = 1; d < 8; d = d * 2) begin
         gn = gp;
         pn = pp;
         for (int unsigned i = d; i < 8; i++) begin
            gn[i] = gp[i] | (pp[i] & gp[i-d]);
            pn[i] = pp[i] & pp[i-d];
         end
         gp = gn;
         pp = pn;
      end
      byte_s    = '0;
      byte_s[0] = p[0] ^ carry_q;
      for (int unsigned i = 1; i < 8; i++) begin
         byte_s[i] = p[i] ^ (gp[i-1] | (pp[i-1] & carry_q));
      end
      byte_c = gp[7] | (pp[7] & carry_q);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub | cin;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = (sum_q & ~(W'(8'hFF) << {k_q, 3'b000})) | (W'(byte_s) << {k_q, 3'b000});
            carry_d = byte_c;
            if (k_q == KW'(NBYTES - 1)) begin
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = carry_q;
   // b_q already holds the inverted operand for subtraction.
   assign ovf       = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);

endmodule
